fifo_rd_arbiter: RTL and testbench



---
 rtl/fifo_rd_arb_pkg.sv | 26 ++
 rtl/fifo_rd_arbiter_rr.sv | 32 +++
 rtl/fifo_rd_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_arb_pkg.sv
// Shared types, default sizes and the burst-length clamp for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_MAX_BURST      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // A zero-length request still moves one beat; oversized requests are capped.
    function automatic int unsigned clamp_burst_len(input int unsigned len,
                                                    input int unsigned max_burst);
        if (len == 0) begin
            return 1;
        end
        if (len > max_burst) begin
            return max_burst;
        end
        return len;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    int unsigned cand;
    logic        found;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr) + 32'(i)) % NUM_REQ;
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter for the FIFO read port (rd_clk domain).
// Define FIFO_RD_ARB_TIMEOUT_EN to force-release a grant stalled on an empty FIFO.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_BURST      = DEF_MAX_BURST,
    parameter int BURST_WIDTH    = $clog2(MAX_BURST + 1),
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           rd_clk,
    input  logic                           rd_rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BURST_WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]             gnt,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [NUM_REQ-1:0]             out_valid,
    output logic                           busy,
    output logic                           timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("fifo_rd_arbiter: illegal parameter combination");
    end

    arb_state_t             state, state_n;
    logic [IDX_W-1:0]       owner, owner_n, rr_ptr, rr_ptr_n, pick_idx;
    logic [NUM_REQ-1:0]     pick, gnt_n, out_valid_n;
    logic [BURST_WIDTH-1:0] count, count_n;
    logic [BURST_WIDTH-1:0] len_arr [NUM_REQ];
    logic                   busy_n, beat, burst_exit, stall_expire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = req_len[i*BURST_WIDTH +: BURST_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign beat       = (state == BURST) && req[owner] && !fifo_empty;
    assign fifo_rd_en = beat;
    assign out_data   = fifo_rd_data;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall;
    logic               timeout_q;

    assign stall        = (state == BURST) && req[owner] && fifo_empty;
    assign stall_expire = stall && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
    assign timeout      = timeout_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= stall_expire;
            stall_cnt <= (stall && !stall_expire) ? stall_cnt + 1'b1 : '0;
        end
    end
`else
    assign stall_expire = 1'b0;
    assign timeout      = 1'b0;
`endif

    // out_valid reuses gnt as onehot(owner) so it lines up with the FIFO's registered data.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        count_n     = count;
        rr_ptr_n    = rr_ptr;
        gnt_n       = gnt;
        busy_n      = busy;
        out_valid_n = '0;
        burst_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_n = pick_idx;
                    count_n = BURST_WIDTH'(clamp_burst_len(32'(len_arr[pick_idx]), MAX_BURST));
                    gnt_n   = pick;
                    busy_n  = 1'b1;
                    state_n = BURST;
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    burst_exit = 1'b1;
                end else if (beat) begin
                    out_valid_n = gnt;
                    count_n     = count - 1'b1;
                    burst_exit  = (count == BURST_WIDTH'(1));
                end else if (stall_expire) begin
                    burst_exit = 1'b1;
                end
                if (burst_exit) begin
                    state_n  = IDLE;
                    gnt_n    = '0;
                    busy_n   = 1'b0;
                    rr_ptr_n = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            out_valid <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            count     <= count_n;
            rr_ptr    <= rr_ptr_n;
            gnt       <= gnt_n;
            busy      <= busy_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed self-checking bench for fifo_rd_arbiter with a small FIFO read-side model.
module tb_fifo_rd_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int MAX_BURST      = 8;
    localparam int BURST_WIDTH    = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic                           rd_clk = 1'b0;
    logic                           rd_rst_n;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*BURST_WIDTH-1:0] req_len;
    logic [NUM_REQ-1:0]             gnt;
    logic                           fifo_empty;
    logic                           fifo_rd_en;
    logic [DATA_WIDTH-1:0]          fifo_rd_data;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [NUM_REQ-1:0]             out_valid;
    logic                           busy;
    logic                           timeout;

    logic [DATA_WIDTH-1:0] mem [64];
    int                    wr_ptr = 0;
    int                    rd_ptr = 0;
    logic                  force_empty = 1'b0;
    int                    beat_cnt = 0;
    int                    n_vectors = 0;
    int                    n_miscompares = 0;

    fifo_rd_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_BURST      (MAX_BURST),
        .BURST_WIDTH    (BURST_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .req          (req),
        .req_len      (req_len),
        .gnt          (gnt),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    // FIFO model: registered read data, popped on each read-enable edge.
    always @(posedge rd_clk) begin
        if (fifo_rd_en === 1'b1) begin
            fifo_rd_data <= mem[rd_ptr % 64];
            rd_ptr       <= rd_ptr + 1;
            beat_cnt     <= beat_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                                 input logic [NUM_REQ*BURST_WIDTH-1:0] lens);
        req     = r;
        req_len = lens;
        #1;
    endtask

    task automatic pushFifo(input int n, input logic [DATA_WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 64] = base + DATA_WIDTH'(i);
            wr_ptr++;
        end
    endtask

    task automatic doReset();
        rd_rst_n    = 1'b0;
        req         = '0;
        req_len     = '0;
        force_empty = 1'b0;
        tick(2);
        wr_ptr   = rd_ptr;
        rd_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int guard;
        int bad;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] prev_gnt;

        // Reset state, then a reset that lands inside a burst.
        doReset();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        pushFifo(4, 8'h10);
        applyStimulus(4'b0001, 16'h0004);
        tick();
        checkOutput("t1_gnt", gnt, 4'b0001);
        tick();
        checkOutput("t1_rd_en_beat2", fifo_rd_en, 1);
        #2 rd_rst_n = 1'b0;
        #1;
        checkOutput("t1_gnt_in_rst", gnt, 0);
        checkOutput("t1_rd_en_in_rst", fifo_rd_en, 0);
        checkOutput("t1_valid_in_rst", out_valid, 0);
        checkOutput("t1_busy_in_rst", busy, 0);
        b0 = beat_cnt;
        tick(2);
        checkOutput("t1_no_beats_in_rst", beat_cnt - b0, 0);
        rd_rst_n = 1'b1;
        applyStimulus(4'b0011, 16'h1111);
        tick();
        checkOutput("t1_regrant_req0", gnt, 4'b0001);

        // Single 3-beat burst for consumer 1.
        doReset();
        mem[wr_ptr % 64] = 8'hA1; wr_ptr++;
        mem[wr_ptr % 64] = 8'hA2; wr_ptr++;
        mem[wr_ptr % 64] = 8'hA3; wr_ptr++;
        applyStimulus(4'b0010, 16'h0030);
        checkOutput("t2_c0_gnt", gnt, 0);
        checkOutput("t2_c0_rd_en", fifo_rd_en, 0);
        tick();
        checkOutput("t2_c1_gnt", gnt, 4'b0010);
        checkOutput("t2_c1_busy", busy, 1);
        checkOutput("t2_c1_rd_en", fifo_rd_en, 1);
        checkOutput("t2_c1_valid", out_valid, 0);
        tick();
        checkOutput("t2_c2_valid", out_valid, 4'b0010);
        checkOutput("t2_c2_data", out_data, 8'hA1);
        checkOutput("t2_c2_rd_en", fifo_rd_en, 1);
        tick();
        checkOutput("t2_c3_valid", out_valid, 4'b0010);
        checkOutput("t2_c3_data", out_data, 8'hA2);
        tick();
        checkOutput("t2_c4_gnt", gnt, 0);
        checkOutput("t2_c4_busy", busy, 0);
        checkOutput("t2_c4_rd_en", fifo_rd_en, 0);
        checkOutput("t2_c4_valid", out_valid, 4'b0010);
        checkOutput("t2_c4_data", out_data, 8'hA3);
        applyStimulus(4'b0111, 16'h0111);
        tick();
        checkOutput("t2_next_gnt_rr2", gnt, 4'b0100);
        checkOutput("t2_c5_valid", out_valid, 0);

        // Fairness: everyone requests 2 beats, grant order 0,1,2,3,0 with one idle gap.
        doReset();
        pushFifo(16, 8'h40);
        applyStimulus(4'b1111, 16'h2222);
        prev_gnt = '0;
        for (int k = 0; k < 14; k++) begin
            tick();
            exp_gnt = (k % 3 == 2) ? 4'b0000 : 4'(1 << ((k / 3) % 4));
            checkOutput($sformatf("t3_gnt_c%0d", k + 1), gnt, exp_gnt);
            checkOutput($sformatf("t3_rd_en_c%0d", k + 1), fifo_rd_en, (exp_gnt != 0));
            checkOutput($sformatf("t3_valid_c%0d", k + 1), out_valid, prev_gnt);
            prev_gnt = exp_gnt;
        end

        // Empty stall after beat 1 of 4, then recovery.
        doReset();
        pushFifo(4, 8'h60);
        b0 = beat_cnt;
        applyStimulus(4'b0001, 16'h0004);
        tick(2);
        force_empty = 1'b1;
        #1;
        checkOutput("t4_beats_before_stall", beat_cnt - b0, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4_stall_rd_en_%0d", i), fifo_rd_en, 0);
            checkOutput($sformatf("t4_stall_gnt_%0d", i), gnt, 4'b0001);
            tick();
        end
        force_empty = 1'b0;
        guard = 0;
        while (gnt !== 4'b0000 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("t4_released", gnt, 0);
        checkOutput("t4_total_beats", beat_cnt - b0, 4);

        // Request drop, then clamp of length 0 and length 12.
        doReset();
        pushFifo(16, 8'h80);
        applyStimulus(4'b1100, 16'h0400);
        tick();
        checkOutput("t5_gnt_req2", gnt, 4'b0100);
        tick();
        applyStimulus(4'b1000, 16'h0400);
        checkOutput("t5_drop_rd_en", fifo_rd_en, 0);
        tick();
        checkOutput("t5_drop_gnt", gnt, 0);
        checkOutput("t5_drop_busy", busy, 0);
        tick();
        checkOutput("t5_gnt_req3", gnt, 4'b1000);
        checkOutput("t5_len0_rd_en", fifo_rd_en, 1);
        tick();
        checkOutput("t5_len0_done", gnt, 0);
        checkOutput("t5_len0_valid", out_valid, 4'b1000);
        b0 = beat_cnt;
        applyStimulus(4'b0001, 16'h000C);
        tick();
        checkOutput("t5_gnt_req0", gnt, 4'b0001);
        guard = 0;
        while (gnt !== 4'b0000 && guard < 30) begin
            tick();
            guard++;
        end
        checkOutput("t5_len12_released", gnt, 0);
        checkOutput("t5_len12_beats", beat_cnt - b0, 8);

        // Stall on an empty FIFO: forced release with the timeout, held forever without it.
        doReset();
        force_empty = 1'b1;
        applyStimulus(4'b0001, 16'h0004);
        tick();
        bad = 0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
            tick();
        end
        checkOutput("t6_held_until_timeout", bad, 0);
        checkOutput("t6_timeout_pulse", timeout, 1);
        checkOutput("t6_timeout_gnt", gnt, 0);
        checkOutput("t6_timeout_busy", busy, 0);
        applyStimulus(4'b0011, 16'h0044);
        tick();
        checkOutput("t6_timeout_one_cycle", timeout, 0);
        checkOutput("t6_rr_advanced", gnt, 4'b0010);
`else
        for (int i = 0; i < 110; i++) begin
            if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
            tick();
        end
        checkOutput("t6_held_cycles_bad", bad, 0);
        checkOutput("t6_still_granted", gnt, 4'b0001);
        checkOutput("t6_timeout_low", timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
